// File: rtl/data_memory_unit.sv
//==============================================================================
// Module      : data_memory_unit
// Description : Y86 data memory with a fixed-latency request/response FSM,
//               range checking and a saturating error counter. Optional
//               macro DMEM_ALIGN_CHECK_EN flags misaligned accesses as errors.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_memory_unit #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 64,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valP,
    output logic [DATA_W-1:0] valM,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic              dmem_error,
    output logic [15:0]       err_cnt
);

    localparam int                c_IDX_W = $clog2(DEPTH);
    localparam int                c_CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DATA_W-1:0] c_LIMIT = DATA_W'(DEPTH * 8);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   valM_q, valM_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                dmem_error_q, dmem_error_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                w_dec_rd;
    logic                w_dec_wr;
    logic                w_dec_addr_a;
    logic                w_misalign;
    logic                w_err;
    logic                w_commit;
    logic                w_mem_we;
    logic [c_IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0]   w_rdata;

    // ret/popq address through valA (stack pointer); everything else via valE
    always_comb begin
        w_dec_rd     = 1'b0;
        w_dec_wr     = 1'b0;
        w_dec_addr_a = 1'b0;
        case (icode)
            4'h4, 4'h8, 4'hA: w_dec_wr = 1'b1;
            4'h5:             w_dec_rd = 1'b1;
            4'h9, 4'hB: begin
                w_dec_rd     = 1'b1;
                w_dec_addr_a = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = (addr_q[2:0] != 3'd0);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err    = (mem_read_q | mem_write_q) & ((addr_q >= c_LIMIT) | w_misalign);
    assign w_idx    = addr_q[c_IDX_W+2:3];
    assign w_rdata  = mem[w_idx];
    assign w_commit = (state_q == S_ACCESS) && (cnt_q == '0);
    assign w_mem_we = w_commit & mem_write_q & ~w_err;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        valM_d       = valM_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        dmem_error_d = dmem_error_q;
        err_cnt_d    = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ACCESS;
                    cnt_d       = c_CNT_W'(LAT - 1);
                    addr_d      = w_dec_addr_a ? valA : valE;
                    wdata_d     = (icode == 4'h8) ? valP : valA;
                    mem_read_d  = w_dec_rd;
                    mem_write_d = w_dec_wr;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d      = S_RESP;
                    dmem_error_d = w_err;
                    valM_d       = (mem_read_q && !w_err) ? w_rdata : '0;
                    if (w_err && (err_cnt_q != 16'hFFFF))
                        err_cnt_d = err_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d      = S_IDLE;
                valM_d       = '0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                dmem_error_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            valM_q       <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            dmem_error_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            valM_q       <= valM_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            dmem_error_q <= dmem_error_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Storage is deliberately not reset so contents survive an aborted request
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst)
            mem[w_idx] <= wdata_q;
    end

    assign valM       = valM_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_RESP);
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign dmem_error = dmem_error_q;
    assign err_cnt    = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_unit.sv
//==============================================================================
// Module      : tb_data_memory_unit
// Description : Bench for data_memory_unit; one LAT=1 and one LAT=4 instance
//               checked against a word-array reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_data_memory_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;

    logic [63:0] valM1, valM4;
    logic        busy1, done1, rd1, wr1, er1;
    logic        busy4, done4, rd4, wr4, er4;
    logic [15:0] ec1, ec4;

    int total = 0;
    int bad   = 0;

    logic [63:0] m1 [int];
    logic [63:0] m4 [int];
    int          ecm1 = 0;
    int          ecm4 = 0;

    always #5 clk = ~clk;

    data_memory_unit #(.DEPTH(1024), .DATA_W(64), .LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP), .valM(valM1),
        .busy(busy1), .done(done1), .mem_read(rd1), .mem_write(wr1),
        .dmem_error(er1), .err_cnt(ec1)
    );

    data_memory_unit #(.DEPTH(1024), .DATA_W(64), .LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .icode(icode),
        .valE(valE), .valA(valA), .valP(valP), .valM(valM4),
        .busy(busy4), .done(done4), .mem_read(rd4), .mem_write(wr4),
        .dmem_error(er4), .err_cnt(ec4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input bit sel, input string tag);
        chk({tag, "_busy"}, sel ? busy4 : busy1, 0);
        chk({tag, "_done"}, sel ? done4 : done1, 0);
        chk({tag, "_rd"},   sel ? rd4 : rd1, 0);
        chk({tag, "_wr"},   sel ? wr4 : wr1, 0);
        chk({tag, "_err"},  sel ? er4 : er1, 0);
        chk({tag, "_valM"}, sel ? valM4 : valM1, 0);
    endtask

    // One complete request with the expected result derived from the ISA rules
    task automatic req(input bit sel, input logic [3:0] ic,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p);
        int          lat;
        int          n;
        int          widx;
        bit          rd, wr, err, known;
        logic [63:0] addr, wd, expm;
        lat  = sel ? 4 : 1;
        rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        addr = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
        wd   = (ic == 4'h8) ? p : a;
        err  = (rd || wr) && (addr >= 64'd8192);
`ifdef DMEM_ALIGN_CHECK_EN
        if ((rd || wr) && (addr[2:0] != 3'd0)) err = 1'b1;
`endif
        widx  = int'(addr[12:3]);
        known = 1'b0;
        expm  = '0;
        if (rd && !err) begin
            if (sel && m4.exists(widx)) begin known = 1'b1; expm = m4[widx]; end
            if (!sel && m1.exists(widx)) begin known = 1'b1; expm = m1[widx]; end
        end

        @(negedge clk);
        icode = ic; valE = e; valA = a; valP = p;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        valE  = {$urandom, $urandom};
        valA  = {$urandom, $urandom};
        valP  = {$urandom, $urandom};
        icode = 4'($urandom);
        n = 1;
        chk("busy_access", sel ? busy4 : busy1, 1);
        chk("rd_access",   sel ? rd4 : rd1, rd);
        chk("wr_access",   sel ? wr4 : wr1, wr);
        while (!(sel ? done4 : done1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(lat + 1));
        if (known || err) chk("valM", sel ? valM4 : valM1, err ? 64'd0 : expm);
        chk("rd_resp",  sel ? rd4 : rd1, rd);
        chk("wr_resp",  sel ? wr4 : wr1, wr);
        chk("dmem_err", sel ? er4 : er1, err);
        if (err) begin
            if (sel) begin if (ecm4 < 65535) ecm4++; end
            else     begin if (ecm1 < 65535) ecm1++; end
        end
        if (wr && !err) begin
            if (sel) m4[widx] = wd; else m1[widx] = wd;
        end
        chk("err_cnt", sel ? 64'(ec4) : 64'(ec1), sel ? 64'(ecm4) : 64'(ecm1));
        @(negedge clk);
        chk_idle(sel, "after");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          pulses;
        int          first;
        logic [63:0] d;
        logic [3:0]  ics [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                  4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF, 4'h4, 4'hB};

        rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
        icode = '0; valE = '0; valA = '0; valP = '0;
        repeat (3) @(negedge clk);
        chk_idle(0, "reset1");
        chk_idle(1, "reset4");
        chk("reset_ec1", 64'(ec1), 0);
        chk("reset_ec4", 64'(ec4), 0);
        rst = 1'b0;

        // write then read back the same word
        req(0, 4'h4, 64'h40, 64'h1234, 64'h0);
        req(0, 4'h5, 64'h40, 64'h0, 64'h0);
        // pushq to the last word, popq it back
        req(0, 4'hA, 64'h1FF8, 64'hAA, 64'h0);
        req(0, 4'hB, 64'h0, 64'h1FF8, 64'h0);
        // out-of-range call must not alias onto word 0
        req(0, 4'h4, 64'h0, 64'h5555_0000_1111_2222, 64'h0);
        req(0, 4'h8, 64'h2000, 64'h0, 64'hDEAD_BEEF);
        req(0, 4'h5, 64'h0, 64'h0, 64'h0);
        // misaligned read inside word 0x40
        req(0, 4'h5, 64'h44, 64'h0, 64'h0);

        // start held for three cycles on the LAT=4 instance
        d = 64'hCAFE_F00D_0123_4567;
        @(negedge clk);
        icode = 4'h4; valE = 64'h80; valA = d; valP = '0; start4 = 1'b1;
        pulses = 0; first = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) start4 = 1'b0;
            if (done4) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("hold_pulses", 64'(pulses), 1);
        chk("hold_done_at", 64'(first), 5);
        m4[16] = d;
        req(1, 4'h5, 64'h80, 64'h0, 64'h0);

        // reset in the middle of a write aborts it
        req(1, 4'h4, 64'h40, 64'h0102_0304_0506_0708, 64'h0);
        @(negedge clk);
        icode = 4'h4; valE = 64'h40; valA = 64'hFFFF_EEEE_DDDD_CCCC; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", busy4, 1);
        #1 rst = 1'b1;
        #1;
        chk_idle(1, "midrst");
        chk("midrst_ec4", 64'(ec4), 0);
        ecm1 = 0; ecm4 = 0;
        @(negedge clk);
        rst = 1'b0;
        req(1, 4'h5, 64'h40, 64'h0, 64'h0);

        for (int k = 0; k < 40; k++) begin
            int          r;
            logic [63:0] ad;
            bit          s;
            s  = 1'($urandom);
            r  = int'($urandom % 8);
            ad = 64'(($urandom % 8) * 8);
            if (r == 5) ad = ad + 64'($urandom % 8);
            if (r == 6) ad = 64'h2000 + 64'(($urandom % 64) * 8);
            if (r == 7) ad = 64'h1FF8;
            req(s, ics[$urandom % 16], ad, (r == 7 || r == 6) ? ad : {$urandom, $urandom},
                {$urandom, $urandom});
            if ($urandom % 2 == 1) begin
                logic [3:0] ric;
                ric = ($urandom % 2 == 1) ? 4'h5 : 4'hB;
                req(s, ric, ad, ad, 64'h0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of DATA_W-bit words, power of two, 16..65536.
REQ-002 SHALL have parameter DATA_W, default 64, word and operand width, 32 or 64.
REQ-003 SHALL have parameter LAT, default 1, access cycles from accept to RESP, 1..8.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request; accepted on an edge where start=1 and busy=0.
REQ-007 SHALL have port icode  input  4  Y86 instruction code selecting the operation.
REQ-008 SHALL have ports valE, valA, valP  input  DATA_W each  address/data operands.
REQ-009 SHALL have port valM  output  DATA_W  read data, valid while done=1.
REQ-010 SHALL have ports busy, done  output  1 each  state!=IDLE; one-cycle completion pulse.
REQ-011 SHALL have ports mem_read, mem_write, dmem_error  output  1 each  registered access type and error.
REQ-012 SHALL have port err_cnt  output  16  saturating count of errored accesses.

Function
REQ-013 SHALL decode on accept: 4 rmmovq write valA@valE; 8 call write valP@valE; A pushq write valA@valE; 5 mrmovq read @valE; 9 ret and B popq read @valA; other codes no access.
REQ-014 SHALL latch operation, address and write data at accept; later operand changes have no effect.
REQ-015 SHALL treat the address as a byte address: word index = addr[log2(DEPTH)+2:3]; in range iff unsigned addr < DEPTH*8.
REQ-016 SHALL implement FSM IDLE -> ACCESS (on accept, cnt=LAT-1) -> RESP (at edge where cnt==0, cnt decrements otherwise) -> IDLE (next edge, unconditionally).
REQ-017 SHALL commit writes and sample reads at the ACCESS->RESP edge; done=1 only in RESP; start-to-done latency LAT+1 cycles.
REQ-018 SHALL hold mem_read/mem_write high in ACCESS and RESP per latched operation, low in IDLE and for no-access codes.
REQ-019 SHALL on out-of-range address: suppress write, valM=0, dmem_error=1 in RESP, err_cnt+1 saturating at 16'hFFFF.
REQ-020 SHALL drive valM=0 and dmem_error=0 outside RESP; no-access codes complete with done=1, no error.
REQ-021 SHALL ignore start while busy=1 (no queueing); start in RESP is dropped.
REQ-022 SHALL return, on a read in the request following a write to the same word, the newly written data.

Reset
REQ-023 SHALL, while rst=1 at any time, force IDLE, busy/done/mem_read/mem_write/dmem_error=0, valM=0, err_cnt=0.
REQ-024 SHALL abort an in-flight request on mid-operation reset with no write committed; memory contents are not reset.

Configuration
REQ-025 SHALL, with macro DMEM_ALIGN_CHECK_EN defined, treat addr[2:0]!=0 on any access as an error (REQ-019 behaviour).
REQ-026 SHALL, without DMEM_ALIGN_CHECK_EN, ignore addr[2:0] and perform the access on the containing word.

Verification
REQ-027 SHALL check: LAT=1, icode=4, valE=0x40, valA=0x1234 then icode=5, valE=0x40 -> second done 2 cycles after start, valM=0x1234, mem_read=1.
REQ-028 SHALL check: icode=A, valE=0x1FF8, valA=0xAA then icode=B, valA=0x1FF8 -> valM=0xAA, dmem_error=0.
REQ-029 SHALL check: icode=8, valE=0x2000 (DEPTH=1024) -> dmem_error=1 in RESP, err_cnt=1, no write.
REQ-030 SHALL check: LAT=4, start held 3 cycles -> one access, done at cycle 5 only, extra starts dropped.
REQ-031 SHALL check: write to 0x40 with rst pulsed in ACCESS (LAT=4) -> all outputs 0 immediately, later read of 0x40 returns prior contents.
REQ-032 SHALL check: icode=5, valE=0x44 -> dmem_error=1 with DMEM_ALIGN_CHECK_EN; word 0x40 data returned without it.
